// File: rtl/uart_tx_rx_module.sv
// rtl/uart_tx_rx_module.sv - full-duplex UART endpoint (independent TX and RX on one clock)
//
// Transmitter: a rising edge on IN_TX_LAUNCH while idle captures IN_TX_DATA and
// sends start / data (LSB first) / optional parity / stop bits, each bit held for
// CLOCK_FREQUENCY/UART_BAUD_RATE clocks.
// Receiver: double-synchronises the serial input, samples each bit at its centre,
// checks parity and stop bits, and strobes the received word out.
//
// Optional build macro: UART_LOOPBACK_EN adds IN_LOOPBACK, which feeds the TX line
// straight into the RX synchroniser when high.
//
// Ports:
//   IN_CLOCK                 system clock, rising edge
//   IN_RESET_N               asynchronous active-low reset
//   IN_LOOPBACK              (UART_LOOPBACK_EN only) route TX line into RX
//   IN_TX_LAUNCH             transmit request, rising-edge detected
//   IN_TX_DATA               word to send, captured at launch
//   OUT_TX_SERIAL            serial line, idle high
//   OUT_TX_ACTIVE            high from start bit through last stop cycle
//   OUT_TX_DONE              one-cycle pulse after the frame
//   OUT_TX_START_BIT_ACTIVE  high during the start bit
//   OUT_TX_STOP_BIT_ACTIVE   high during the stop bit(s)
//   IN_RX_SERIAL             asynchronous serial input
//   OUT_RX_DATA              last received word
//   OUT_RX_DATA_READY        one-cycle pulse when a frame completes
//   OUT_RX_ERROR             parity or framing error of the last completed frame

module uart_tx_rx_module #(
  parameter int UART_BAUD_RATE           = 9600,
  parameter int CLOCK_FREQUENCY          = 38400,
  parameter int PARITY                   = 2,
  parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
  parameter int NUMBER_STOP_BITS         = 1
) (
  input  logic                                IN_CLOCK,
  input  logic                                IN_RESET_N,
`ifdef UART_LOOPBACK_EN
  input  logic                                IN_LOOPBACK,
`endif
  input  logic                                IN_TX_LAUNCH,
  input  logic [NUM_OF_DATA_BITS_IN_PACK-1:0] IN_TX_DATA,
  output logic                                OUT_TX_SERIAL,
  output logic                                OUT_TX_ACTIVE,
  output logic                                OUT_TX_DONE,
  output logic                                OUT_TX_START_BIT_ACTIVE,
  output logic                                OUT_TX_STOP_BIT_ACTIVE,
  input  logic                                IN_RX_SERIAL,
  output logic [NUM_OF_DATA_BITS_IN_PACK-1:0] OUT_RX_DATA,
  output logic                                OUT_RX_DATA_READY,
  output logic                                OUT_RX_ERROR
);

  localparam int CPB       = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int NDB       = NUM_OF_DATA_BITS_IN_PACK;
  localparam int STOP_CLKS = NUMBER_STOP_BITS * CPB;
  localparam int CNT_W     = $clog2(STOP_CLKS + 1);
  localparam int BIT_W     = $clog2(NDB + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] BIT_MID   = CNT_W'(CPB / 2);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(NDB - 1);
  localparam logic             STOP_IDX_LAST = 1'(NUMBER_STOP_BITS - 1);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  tx_state_t          tx_state;
  logic               launch_q;
  logic [NDB-1:0]     tx_shift;
  logic               tx_par;
  logic [CNT_W-1:0]   tx_cnt;
  logic [BIT_W-1:0]   tx_bit;

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      tx_state                <= TX_IDLE;
      launch_q                <= 1'b0;
      tx_shift                <= '0;
      tx_par                  <= 1'b0;
      tx_cnt                  <= '0;
      tx_bit                  <= '0;
      OUT_TX_SERIAL           <= 1'b1;
      OUT_TX_ACTIVE           <= 1'b0;
      OUT_TX_DONE             <= 1'b0;
      OUT_TX_START_BIT_ACTIVE <= 1'b0;
      OUT_TX_STOP_BIT_ACTIVE  <= 1'b0;
    end else begin
      // launch_q follows the input every cycle, so an edge that arrives while
      // busy is consumed and a level held across the frame cannot relaunch.
      launch_q    <= IN_TX_LAUNCH;
      OUT_TX_DONE <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (IN_TX_LAUNCH && !launch_q) begin
            tx_shift                <= IN_TX_DATA;
            tx_par                  <= (PARITY == 1) ? ~^IN_TX_DATA : ^IN_TX_DATA;
            tx_cnt                  <= '0;
            tx_state                <= TX_START;
            OUT_TX_SERIAL           <= 1'b0;
            OUT_TX_ACTIVE           <= 1'b1;
            OUT_TX_START_BIT_ACTIVE <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt                  <= '0;
            tx_bit                  <= '0;
            tx_state                <= TX_DATA;
            OUT_TX_SERIAL           <= tx_shift[0];
            OUT_TX_START_BIT_ACTIVE <= 1'b0;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == DATA_LAST) begin
              if (PARITY != 0) begin
                tx_state      <= TX_PARITY;
                OUT_TX_SERIAL <= tx_par;
              end else begin
                tx_state               <= TX_STOP;
                OUT_TX_SERIAL          <= 1'b1;
                OUT_TX_STOP_BIT_ACTIVE <= 1'b1;
              end
            end else begin
              // The line is driven from bit 1 because bit 0 is the one
              // currently on the wire and is dropped by this shift.
              tx_bit        <= tx_bit + 1'b1;
              tx_shift      <= tx_shift >> 1;
              OUT_TX_SERIAL <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_PARITY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt                 <= '0;
            tx_state               <= TX_STOP;
            OUT_TX_SERIAL          <= 1'b1;
            OUT_TX_STOP_BIT_ACTIVE <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == STOP_LAST) begin
            tx_cnt                 <= '0;
            tx_state               <= TX_DONE;
            OUT_TX_ACTIVE          <= 1'b0;
            OUT_TX_STOP_BIT_ACTIVE <= 1'b0;
            OUT_TX_DONE            <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DONE: begin
          tx_state <= TX_IDLE;
        end
        default: begin
          tx_state      <= TX_IDLE;
          OUT_TX_SERIAL <= 1'b1;
          OUT_TX_ACTIVE <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = IN_LOOPBACK ? OUT_TX_SERIAL : IN_RX_SERIAL;
`else
  assign rx_src = IN_RX_SERIAL;
`endif

  rx_state_t          rx_state;
  logic               rx_meta;
  logic               rx_sync;
  logic [NDB-1:0]     rx_shift;
  logic [CNT_W-1:0]   rx_cnt;
  logic [BIT_W-1:0]   rx_bit;
  logic               rx_stop_idx;
  logic               parity_err;
  logic               framing_err;
  logic               rx_mid;
  logic               rx_par_exp;

  assign rx_mid     = (rx_cnt == BIT_MID);
  assign rx_par_exp = (PARITY == 1) ? ~^rx_shift : ^rx_shift;

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      rx_state          <= RX_IDLE;
      rx_meta           <= 1'b1;
      rx_sync           <= 1'b1;
      rx_shift          <= '0;
      rx_cnt            <= '0;
      rx_bit            <= '0;
      rx_stop_idx       <= 1'b0;
      parity_err        <= 1'b0;
      framing_err       <= 1'b0;
      OUT_RX_DATA       <= '0;
      OUT_RX_DATA_READY <= 1'b0;
      OUT_RX_ERROR      <= 1'b0;
    end else begin
      rx_meta           <= rx_src;
      rx_sync           <= rx_meta;
      OUT_RX_DATA_READY <= 1'b0;

      // Bit-phase counter wraps every bit period; the cycle that detected the
      // falling level is phase 0, so START is entered at phase 1 and every
      // sample lands on phase CPB/2.
      if (rx_state != RX_IDLE) begin
        rx_cnt <= (rx_cnt == BIT_LAST) ? '0 : rx_cnt + 1'b1;
      end

      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state    <= RX_START;
            rx_cnt      <= CNT_W'(1);
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
          end
        end
        RX_START: begin
          if (rx_mid) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
            end
          end
        end
        RX_DATA: begin
          if (rx_mid) begin
            rx_shift <= {rx_sync, rx_shift[NDB-1:1]};
            if (rx_bit == DATA_LAST) begin
              rx_stop_idx <= 1'b0;
              rx_state    <= (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_mid) begin
            parity_err <= (rx_sync != rx_par_exp);
            rx_state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_mid) begin
            if (rx_stop_idx == STOP_IDX_LAST) begin
              OUT_RX_DATA       <= rx_shift;
              OUT_RX_DATA_READY <= 1'b1;
              OUT_RX_ERROR      <= parity_err | framing_err | !rx_sync;
              rx_state          <= RX_IDLE;
            end else begin
              framing_err <= framing_err | !rx_sync;
              rx_stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_rx_module.sv
// tb/tb_uart_tx_rx_module.sv - self-checking bench for uart_tx_rx_module (two cross-connected instances)

module tb_uart_tx_rx_module;

  localparam int CPB        = 4;
  localparam int FRAME_BITS = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       launch1, launch2;
  logic [7:0] tx1_data, tx2_data;
  logic       ser1, act1, done1, sb1, pb1;
  logic       ser2, act2, done2, sb2, pb2;
  logic [7:0] rx1_data, rx2_data;
  logic       rx1_rdy, rx2_rdy, rx1_err, rx2_err;
  logic       inj_sel, inj_line, rx2_in;

  assign rx2_in = inj_sel ? inj_line : ser1;

  uart_tx_rx_module u1 (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n),
    .IN_TX_LAUNCH(launch1), .IN_TX_DATA(tx1_data),
    .OUT_TX_SERIAL(ser1), .OUT_TX_ACTIVE(act1), .OUT_TX_DONE(done1),
    .OUT_TX_START_BIT_ACTIVE(sb1), .OUT_TX_STOP_BIT_ACTIVE(pb1),
    .IN_RX_SERIAL(ser2), .OUT_RX_DATA(rx1_data),
    .OUT_RX_DATA_READY(rx1_rdy), .OUT_RX_ERROR(rx1_err)
  );

  uart_tx_rx_module u2 (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n),
    .IN_TX_LAUNCH(launch2), .IN_TX_DATA(tx2_data),
    .OUT_TX_SERIAL(ser2), .OUT_TX_ACTIVE(act2), .OUT_TX_DONE(done2),
    .OUT_TX_START_BIT_ACTIVE(sb2), .OUT_TX_STOP_BIT_ACTIVE(pb2),
    .IN_RX_SERIAL(rx2_in), .OUT_RX_DATA(rx2_data),
    .OUT_RX_DATA_READY(rx2_rdy), .OUT_RX_ERROR(rx2_err)
  );

  int total = 0;
  int bad   = 0;

  int         rx1_cnt = 0, rx2_cnt = 0;
  logic [7:0] rx1_last = '0, rx2_last = '0;
  logic       rx1_lerr = 1'b0, rx2_lerr = 1'b0;

  always @(negedge clk) begin
    if (rx1_rdy === 1'b1) begin
      rx1_cnt++;
      rx1_last = rx1_data;
      rx1_lerr = rx1_err;
    end
    if (rx2_rdy === 1'b1) begin
      rx2_cnt++;
      rx2_last = rx2_data;
      rx2_lerr = rx2_err;
    end
  end

  typedef struct {
    logic [7:0] data;
    bit         flip_par;
    bit         stop0;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as a bit list, index 0 = start bit; even parity makes the count of
  // ones in data+parity even.
  function automatic logic [10:0] frame_of(input logic [7:0] d, input bit flip_par, input bit stop0);
    int   ones;
    logic par;
    ones = $countones(d);
    par  = (ones % 2 == 1);
    if (flip_par) par = !par;
    return {(stop0 ? 1'b0 : 1'b1), par, d, 1'b0};
  endfunction

  task automatic check_tx_frame(input logic [7:0] d, input int hold);
    logic [10:0] f;
    int          extra;
    f = frame_of(d, 1'b0, 1'b0);
    @(negedge clk);
    tx1_data = d;
    launch1  = 1'b1;
    for (int i = 0; i < FRAME_BITS * CPB; i++) begin
      @(negedge clk);
      if (i == 0) tx1_data = ~d;
      chk("tx_line", 32'({ser1, act1, sb1, pb1, done1}),
          32'({f[4'(i / CPB)], 1'b1, (i < CPB), (i >= (FRAME_BITS - 1) * CPB), 1'b0}));
      if (i == hold - 1) launch1 = 1'b0;
    end
    @(negedge clk);
    chk("tx_done", 32'({ser1, act1, done1, sb1, pb1}), 32'(5'b10100));
    extra = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (act1 || done1 || !ser1) extra++;
    end
    chk("tx_single_frame", extra, 0);
  endtask

  task automatic inject(input logic [10:0] f);
    for (int b = 0; b < FRAME_BITS; b++) begin
      inj_line = f[b];
      repeat (CPB) @(negedge clk);
    end
    inj_line = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_rx(input int which, input int prev, input logic [7:0] d, input logic e);
    int n;
    n = 0;
    while (((which == 1) ? rx1_cnt : rx2_cnt) == prev && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rx_timeout", 32'(n < 400), 32'(1));
    repeat (8) @(negedge clk);
    if (which == 1) begin
      chk("rx1_pulses", rx1_cnt - prev, 1);
      chk("rx1_data", 32'(rx1_last), 32'(d));
      chk("rx1_err", 32'(rx1_lerr), 32'(e));
      chk("rx1_data_held", 32'(rx1_data), 32'(d));
    end else begin
      chk("rx2_pulses", rx2_cnt - prev, 1);
      chk("rx2_data", 32'(rx2_last), 32'(d));
      chk("rx2_err", 32'(rx2_lerr), 32'(e));
      chk("rx2_data_held", 32'(rx2_data), 32'(d));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         prev;
    logic [7:0] d;
    bit         fp, s0;

    vecs[0] = '{8'hCD, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'hCD, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0};

    rst_n    = 1'b0;
    launch1  = 1'b0;
    launch2  = 1'b0;
    tx1_data = '0;
    tx2_data = '0;
    inj_sel  = 1'b0;
    inj_line = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_u1", 32'({ser1, act1, done1, sb1, pb1, rx1_data, rx1_rdy, rx1_err}), 32'({5'b10000, 10'b0}));
    chk("reset_u2", 32'({ser2, act2, done2, sb2, pb2, rx2_data, rx2_rdy, rx2_err}), 32'({5'b10000, 10'b0}));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xCD with launch held 12 cycles, received by u2
    prev = rx2_cnt;
    check_tx_frame(8'hCD, 12);
    expect_rx(2, prev, 8'hCD, 1'b0);

    // u2 echoes what it received back to u1
    prev = rx1_cnt;
    @(negedge clk);
    tx2_data = rx2_data;
    launch2  = 1'b1;
    repeat (2) @(negedge clk);
    launch2 = 1'b0;
    expect_rx(1, prev, 8'hCD, 1'b0);

    // injected frames with parity / stop corruption
    inj_sel = 1'b1;
    repeat (4) @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      prev = rx2_cnt;
      inject(frame_of(vecs[v].data, vecs[v].flip_par, vecs[v].stop0));
      expect_rx(2, prev, vecs[v].data, vecs[v].exp_err);
    end

    // one-cycle glitch on an idle line
    prev = rx2_cnt;
    inj_line = 1'b0;
    @(negedge clk);
    inj_line = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_no_ready", rx2_cnt - prev, 0);
    inject(frame_of(8'h96, 1'b0, 1'b0));
    expect_rx(2, prev, 8'h96, 1'b0);

    // random injected frames
    for (int k = 0; k < 6; k++) begin
      d    = 8'($urandom);
      fp   = 1'($urandom);
      s0   = 1'($urandom);
      prev = rx2_cnt;
      inject(frame_of(d, fp, s0));
      expect_rx(2, prev, d, fp | s0);
    end

    // random words over the link
    inj_sel = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      d    = 8'($urandom);
      prev = rx2_cnt;
      check_tx_frame(d, int'($urandom_range(1, 12)));
      expect_rx(2, prev, d, 1'b0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    tx1_data = 8'h3C;
    launch1  = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx", 32'({ser1, act1, done1, sb1}), 32'(4'b1000));
    chk("async_reset_rx", 32'(rx2_data), 32'(0));
    @(negedge clk);
    launch1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    prev = rx2_cnt;
    check_tx_frame(8'h5A, 1);
    expect_rx(2, prev, 8'h5A, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
